// File: rtl/prirv32_pkg.sv
// Shared definitions for the priRV32 branch resolution unit: PHT counter
// encodings, BRU FSM states and the default predictor depth.
package priRV32_pkg;

  localparam logic [1:0] CNT_STRONG_TOKEN   = 2'b00;
  localparam logic [1:0] CNT_WEAK_TOKEN     = 2'b01;
  localparam logic [1:0] CNT_WEAK_NOTOKEN   = 2'b10;
  localparam logic [1:0] CNT_STRONG_NOTOKEN = 2'b11;

  localparam int PHT_ENTRIES_DEF = 16;

  typedef enum logic [1:0] {
    BRU_IDLE     = 2'd0,
    BRU_REDIRECT = 2'd1,
    BRU_FLUSH    = 2'd2
  } bru_state_e;

  // Taken moves toward STRONG_TOKEN (00), not-taken toward STRONG_NOTOKEN (11).
  function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_STRONG_TOKEN) nxt = cnt - 2'd1;
    end else begin
      if (cnt != CNT_STRONG_NOTOKEN) nxt = cnt + 2'd1;
    end
    return nxt;
  endfunction

  function automatic logic cnt_predicts_taken(input logic [1:0] cnt);
    return (cnt == CNT_STRONG_TOKEN) || (cnt == CNT_WEAK_TOKEN);
  endfunction

endpackage

// File: rtl/prirv32_pht.sv
// Pattern history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous training port.
module priRV32_PHT
  import priRV32_pkg::*;
#(
  parameter int ENTRIES = PHT_ENTRIES_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
  output logic [1:0]                 rd_cnt_o,
  input  logic                       wr_en_i,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx_i,
  input  logic                       wr_taken_i
);

  logic [1:0] cnt_q [ENTRIES];

  // Read returns the stored value, so a same-cycle update is not visible yet.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WEAK_NOTOKEN;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= cnt_train(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/prirv32_bru.sv
// Branch resolution unit: PHT prediction/training plus mispredict redirect
// and flush sequencing. Optional counters enabled by PRIRV32_BRU_STATS_EN.
module prirv32_bru
  import priRV32_pkg::*;
#(
  parameter int PHT_ENTRIES  = PHT_ENTRIES_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc_i,
  output logic        lookup_taken_o,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic [31:0] res_pc_i,
  input  logic        res_is_cond_i,
  input  logic        res_taken_i,
  input  logic [31:0] res_target_i,
  input  logic [31:0] res_pred_pc_i,
  output logic        redirect_valid_o,
  input  logic        redirect_ready_i,
  output logic [31:0] redirect_pc_o,
`ifdef PRIRV32_BRU_STATS_EN
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o,
`endif
  output logic        flush_o
);

  localparam int         IDX_W   = $clog2(PHT_ENTRIES);
  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

  logic [1:0]  lk_cnt;
  logic [31:0] next_pc;
  logic        mispred;
  logic        accept;
  logic        unused_lookup_bits;

  bru_state_e  state_q;
  logic [31:0] rpc_q;
  logic        rv_q;
  logic        flush_q;
  logic        ready_q;
  logic [3:0]  fcnt_q;

  assign unused_lookup_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

  priRV32_PHT #(.ENTRIES(PHT_ENTRIES)) u_pht (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .rd_idx_i   (lookup_pc_i[IDX_W+1:2]),
    .rd_cnt_o   (lk_cnt),
    .wr_en_i    (accept && res_is_cond_i),
    .wr_idx_i   (res_pc_i[IDX_W+1:2]),
    .wr_taken_i (res_taken_i)
  );

  assign lookup_taken_o = cnt_predicts_taken(lk_cnt);

  assign next_pc = res_taken_i ? res_target_i : (res_pc_i + 32'd4);
  assign mispred = (next_pc != res_pred_pc_i);
  assign accept  = res_valid_i && ready_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BRU_IDLE;
      rpc_q   <= 32'd0;
      rv_q    <= 1'b0;
      flush_q <= 1'b0;
      ready_q <= 1'b1;
      fcnt_q  <= 4'd0;
    end else begin
      case (state_q)
        BRU_IDLE: begin
          if (accept && mispred) begin
            state_q <= BRU_REDIRECT;
            rpc_q   <= {next_pc[31:1], 1'b0};
            rv_q    <= 1'b1;
            flush_q <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        BRU_REDIRECT: begin
          if (redirect_ready_i) begin
            state_q <= BRU_FLUSH;
            rv_q    <= 1'b0;
            fcnt_q  <= FLUSH_LD;
          end
        end
        BRU_FLUSH: begin
          // Leaving on the count-of-1 cycle keeps flush high FLUSH_CYCLES cycles.
          if (fcnt_q <= 4'd1) begin
            state_q <= BRU_IDLE;
            flush_q <= 1'b0;
            ready_q <= 1'b1;
            fcnt_q  <= 4'd0;
          end else begin
            fcnt_q  <= fcnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= BRU_IDLE;
          rv_q    <= 1'b0;
          flush_q <= 1'b0;
          ready_q <= 1'b1;
          fcnt_q  <= 4'd0;
        end
      endcase
    end
  end

  assign res_ready_o      = ready_q;
  assign redirect_valid_o = rv_q;
  assign redirect_pc_o    = rpc_q;
  assign flush_o          = flush_q;

`ifdef PRIRV32_BRU_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      branches_q    <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else if (accept) begin
      branches_q <= branches_q + 32'd1;
      if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign stat_branches_o = branches_q;
  assign stat_mispred_o  = mispred_cnt_q;
`endif

endmodule

// File: doc/prirv32_bru.md
PRIRV32_BRU -- requirements
Module: priRV32_BRU

Interface
REQ-001 Parameter PHT_ENTRIES, default 16, number of 2-bit pattern history counters; power of two, 4..64.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles flush_o stays high after redirect acceptance; range 1..15.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 lookup_pc_i  input  32  fetch PC presented by IFU for prediction.
REQ-006 lookup_taken_o  output  1  combinational prediction for lookup_pc_i: 1 when indexed counter is 2'b00 or 2'b01.
REQ-007 res_valid_i / res_ready_o  input / output  1 / 1  resolved-control-transfer handshake from EXU.
REQ-008 res_pc_i  input  32  PC of resolved instruction.
REQ-009 res_is_cond_i  input  1  1 for Bxxx, 0 for JAL/JALR; only conditional branches train the PHT.
REQ-010 res_taken_i  input  1  actual outcome.
REQ-011 res_target_i  input  32  actual taken target.
REQ-012 res_pred_pc_i  input  32  next PC the IFU actually fetched after this instruction.
REQ-013 redirect_valid_o / redirect_ready_i  output / input  1 / 1  redirect handshake to IFU.
REQ-014 redirect_pc_o  output  32  corrected fetch PC; bit 0 forced to 0.
REQ-015 flush_o  output  1  squash younger in-flight instructions.

Function
REQ-016 PHT index: PC[IDX_W+1:2], IDX_W = log2(PHT_ENTRIES); same mapping for lookup and update.
REQ-017 Counter encoding: 00 STRONG_TOKEN, 01 WEAK_TOKEN, 10 WEAK_NOTOKEN, 11 STRONG_NOTOKEN.
REQ-018 Training: taken decrements and non-taken increments, saturating at 00 and 11; written on the acceptance edge.
REQ-019 Same-cycle lookup and update of one index: lookup_taken_o returns the pre-update value.
REQ-020 Correct next PC: res_taken_i ? res_target_i : res_pc_i + 4 (32-bit wrap); mispredict when it differs from res_pred_pc_i.
REQ-021 FSM states: IDLE, REDIRECT, FLUSH.
REQ-022 IDLE: res_ready_o = 1; on res_valid_i with a mispredict, latch the correct next PC into redirect_pc_o and go to REDIRECT; otherwise stay in IDLE.
REQ-023 REDIRECT: res_ready_o = 0, redirect_valid_o = 1, flush_o = 1; redirect_pc_o stable; on redirect_ready_i, load the flush counter with FLUSH_CYCLES and go to FLUSH.
REQ-024 FLUSH: res_ready_o = 0, redirect_valid_o = 0, flush_o = 1; decrement each cycle; go to IDLE on the cycle the counter reaches 1.
REQ-025 Latency: redirect_valid_o rises one cycle after the mispredicting acceptance edge.
REQ-026 res_valid_i outside IDLE is not accepted; the EXU holds its inputs stable until acceptance.

Reset
REQ-027 While rst_n is low, all PHT counters are 2'b10; the FSM is IDLE; redirect_valid_o = 0, flush_o = 0, redirect_pc_o = 0, flush counter = 0.
REQ-028 Reset asserted mid-REDIRECT or mid-FLUSH drops the pending redirect immediately, with no completion.

Configuration
REQ-029 Macro PRIRV32_BRU_STATS_EN: when defined, adds outputs stat_branches_o[31:0] and stat_mispred_o[31:0].
REQ-030 stat_branches_o increments once per accepted resolution; stat_mispred_o increments once per mispredict; both wrap modulo 2^32; both reset to 0.
REQ-031 Without the macro, those ports and counters do not exist and the remaining behaviour is identical.

Structure
REQ-032 The shared package priRV32_pkg holds the four counter-encoding constants, the BRU FSM state enumeration, and the default PHT_ENTRIES.
REQ-033 The sub-module priRV32_PHT holds the counter array, with one combinational read port and one synchronous saturating-update port.

Verification
REQ-034 After reset, lookup_pc_i = 0x40 -> lookup_taken_o = 0 for every index.
REQ-035 Conditional branch at 0x100, taken, accepted twice with correct pred -> counter 10→01→00; lookup 0x100 -> 1; third taken keeps 00.
REQ-036 Conditional at 0x200, taken, target 0x180, res_pred_pc_i = 0x204 -> next cycle redirect_valid_o = 1, redirect_pc_o = 0x180, flush_o = 1; redirect_ready_i held low 3 cycles -> outputs stable, res_ready_o = 0.
REQ-037 redirect_ready_i = 1 with FLUSH_CYCLES = 2 -> flush_o high exactly 2 further cycles, then res_ready_o = 1.
REQ-038 JALR resolution at 0x300, target 0x501, pred 0x304 -> redirect_pc_o = 0x500; PHT entry 0 unchanged.
REQ-039 rst_n pulsed low during FLUSH -> flush_o = 0 and redirect_valid_o = 0 immediately; stats = 0 with PRIRV32_BRU_STATS_EN.
